turret_ctrl: RTL and testbench

TURRET_CTRL -- requirements
Module: turret_ctrl

---
 rtl/turret_pkg.sv | 37 +++
 rtl/servo_pwm_ch.sv | 58 +++++
 rtl/turret_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_turret_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turret_pkg.sv
// Shared constants and types for the turret controller: register map,
// fire FSM encoding, servo width field size and the width clamp helper.
package turret_pkg;

    localparam int unsigned WIDTH_W = 21;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_PAN_W  = 8'h04;
    localparam logic [7:0] ADDR_TILT_W = 8'h08;
    localparam logic [7:0] ADDR_FIRE   = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_COOL = 2'd2
    } fire_state_t;

    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_reg_t;

    // Limit a requested pulse width to the servo's legal range
    function automatic logic [WIDTH_W-1:0] clamp_width(
        input logic [WIDTH_W-1:0] w,
        input logic [WIDTH_W-1:0] lo,
        input logic [WIDTH_W-1:0] hi
    );
        logic [WIDTH_W-1:0] r;
        r = w;
        if (w < lo) r = lo;
        else if (w > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo PWM channel: shadow width register refreshed at frame start
// and a registered compare against the shared frame counter.
// Build option TURRET_SLEW_EN: shadow steps toward the target by at most
// SLEW_STEP per frame instead of jumping straight to it.
module servo_pwm_ch
    import turret_pkg::*;
#(
    parameter int unsigned MIN_W = 100000,
    parameter int unsigned CNT_W = 21
`ifdef TURRET_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP = 2000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               frame_start,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [WIDTH_W-1:0] target,
    output logic               pwm
);

    logic [WIDTH_W-1:0] shadow_q;
    logic [WIDTH_W-1:0] shadow_nxt_c;
    logic [WIDTH_W-1:0] width_eff_c;

`ifdef TURRET_SLEW_EN
    localparam logic [WIDTH_W-1:0] STEP_W = WIDTH_W'(SLEW_STEP);

    // Rate-limited move of the shadow toward the programmed width
    always_comb begin
        shadow_nxt_c = target;
        if (target > shadow_q) begin
            if ((target - shadow_q) > STEP_W) shadow_nxt_c = shadow_q + STEP_W;
        end else if ((shadow_q - target) > STEP_W) begin
            shadow_nxt_c = shadow_q - STEP_W;
        end
    end
`else
    assign shadow_nxt_c = target;
`endif

    // At frame start the compare already uses the freshly loaded width
    assign width_eff_c = frame_start ? shadow_nxt_c : shadow_q;

    // Shadow update at frame boundary and registered pulse compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= WIDTH_W'(MIN_W);
            pwm      <= 1'b0;
        end else begin
            if (frame_start) shadow_q <= shadow_nxt_c;
            pwm <= en & (32'(cnt) < 32'(width_eff_c));
        end
    end

endmodule

// File: rtl/turret_ctrl.sv
// APB3 turret controller: two servo PWM channels and a fire/cooldown
// sequencer for the trigger solenoid, with a DONE level interrupt.
// Build option TURRET_SLEW_EN enables per-frame slew limiting of servo widths.
module turret_ctrl
    import turret_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = 2000000,
    parameter int unsigned MIN_W      = 100000,
    parameter int unsigned MAX_W      = 200000,
    parameter int unsigned FIRE_CYC   = 5000000,
    parameter int unsigned COOL_CYC   = 50000000
`ifdef TURRET_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP  = 2000
`endif
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PAN_PWM,
    output logic        TILT_PWM,
    output logic        FIRE_OUT,
    output logic        IRQ
);

    localparam int unsigned CNT_W   = $clog2(PERIOD_CYC);
    localparam int unsigned TMR_MAX = (FIRE_CYC > COOL_CYC) ? FIRE_CYC : COOL_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [WIDTH_W-1:0] MIN_WV = WIDTH_W'(MIN_W);
    localparam logic [WIDTH_W-1:0] MAX_WV = WIDTH_W'(MAX_W);

    ctrl_reg_t          ctrl_q;
    logic [WIDTH_W-1:0] pan_w_q;
    logic [WIDTH_W-1:0] tilt_w_q;
    logic [CNT_W-1:0]   cnt_q;
    fire_state_t        state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               done_q;
    logic               fire_out_q;
    logic               irq_q;
    logic               pslverr_q;

    logic               addr_ok_c;
    logic               wr_c;
    logic               fire_req_c;
    logic               done_clr_c;
    logic               frame_start_c;
    logic [WIDTH_W-1:0] wr_width_c;
    logic [31:0]        prdata_c;
    logic               unused_pwdata_c;

    assign addr_ok_c     = (PADDR <= ADDR_STATUS) && (PADDR[1:0] == 2'b00);
    assign wr_c          = PSEL & PENABLE & PWRITE & addr_ok_c;
    assign fire_req_c    = wr_c && (PADDR == ADDR_FIRE) && PWDATA[0];
    assign done_clr_c    = wr_c && (PADDR == ADDR_STATUS) && PWDATA[1];
    assign wr_width_c    = clamp_width(PWDATA[WIDTH_W-1:0], MIN_WV, MAX_WV);
    assign frame_start_c = ctrl_q.en && (cnt_q == '0);
    assign unused_pwdata_c = &{1'b0, PWDATA[31:WIDTH_W]};

    assign PREADY   = 1'b1;
    assign PSLVERR  = pslverr_q;
    assign FIRE_OUT = fire_out_q;
    assign IRQ      = irq_q;
    assign PRDATA   = prdata_c;

    // Register writes; slave error is raised from the setup phase so it is valid in access
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            ctrl_q    <= '0;
            pan_w_q   <= MIN_WV;
            tilt_w_q  <= MIN_WV;
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= PSEL & ~PENABLE & ~addr_ok_c;
            if (wr_c) begin
                case (PADDR)
                    ADDR_CTRL:   ctrl_q   <= ctrl_reg_t'(PWDATA[1:0]);
                    ADDR_PAN_W:  pan_w_q  <= wr_width_c;
                    ADDR_TILT_W: tilt_w_q <= wr_width_c;
                    default: ;
                endcase
            end
        end
    end

    // Combinational read mux; illegal addresses and FIRE read as zero
    always_comb begin
        prdata_c = '0;
        if (addr_ok_c) begin
            case (PADDR)
                ADDR_CTRL:   prdata_c = {30'd0, ctrl_q};
                ADDR_PAN_W:  prdata_c = 32'(pan_w_q);
                ADDR_TILT_W: prdata_c = 32'(tilt_w_q);
                ADDR_STATUS: prdata_c = {28'd0, state_q, done_q, (state_q != ST_IDLE)};
                default:     prdata_c = '0;
            endcase
        end
    end

    // Servo frame counter, held at zero while disabled
    always_ff @(posedge PCLK) begin
        if (!PRESERN || !ctrl_q.en) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(PERIOD_CYC - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fire sequencer: trigger pulse, cooldown lockout, DONE with set-over-clear priority
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            done_q     <= 1'b0;
            fire_out_q <= 1'b0;
        end else begin
            if (done_clr_c) done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fire_req_c && ctrl_q.en) begin
                        state_q    <= ST_FIRE;
                        tmr_q      <= TMR_W'(FIRE_CYC);
                        fire_out_q <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (!ctrl_q.en) begin
                        state_q    <= ST_IDLE;
                        tmr_q      <= '0;
                        fire_out_q <= 1'b0;
                    end else if (tmr_q == TMR_W'(1)) begin
                        state_q    <= ST_COOL;
                        tmr_q      <= TMR_W'(COOL_CYC);
                        fire_out_q <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_COOL: begin
                    if (!ctrl_q.en) begin
                        state_q <= ST_IDLE;
                        tmr_q   <= '0;
                    end else if (tmr_q == TMR_W'(1)) begin
                        state_q <= ST_IDLE;
                        tmr_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    fire_out_q <= 1'b0;
                end
            endcase
        end
    end

    // Level interrupt from DONE gated by IRQ_EN
    always_ff @(posedge PCLK) begin
        if (!PRESERN) irq_q <= 1'b0;
        else          irq_q <= done_q & ctrl_q.irq_en;
    end

    servo_pwm_ch #(
        .MIN_W(MIN_W),
        .CNT_W(CNT_W)
`ifdef TURRET_SLEW_EN
        ,
        .SLEW_STEP(SLEW_STEP)
`endif
    ) u_pan (
        .clk        (PCLK),
        .rst_n      (PRESERN),
        .en         (ctrl_q.en),
        .frame_start(frame_start_c),
        .cnt        (cnt_q),
        .target     (pan_w_q),
        .pwm        (PAN_PWM)
    );

    servo_pwm_ch #(
        .MIN_W(MIN_W),
        .CNT_W(CNT_W)
`ifdef TURRET_SLEW_EN
        ,
        .SLEW_STEP(SLEW_STEP)
`endif
    ) u_tilt (
        .clk        (PCLK),
        .rst_n      (PRESERN),
        .en         (ctrl_q.en),
        .frame_start(frame_start_c),
        .cnt        (cnt_q),
        .target     (tilt_w_q),
        .pwm        (TILT_PWM)
    );

endmodule

// File: tb/tb_turret_ctrl.sv
// Directed bench for turret_ctrl: register table plus PWM, fire and reset sequences.
module tb_turret_ctrl;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_PAN    = 8'h04;
    localparam logic [7:0] A_TILT   = 8'h08;
    localparam logic [7:0] A_FIRE   = 8'h0C;
    localparam logic [7:0] A_STATUS = 8'h10;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        PAN_PWM;
    logic        TILT_PWM;
    logic        FIRE_OUT;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    turret_ctrl #(
        .PERIOD_CYC(100),
        .MIN_W     (10),
        .MAX_W     (20),
        .FIRE_CYC  (5),
        .COOL_CYC  (8)
    ) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PAN_PWM (PAN_PWM),
        .TILT_PWM(TILT_PWM),
        .FIRE_OUT(FIRE_OUT),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 begin d = PRDATA; err = PSLVERR; end
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic err;
        apb_write(a, d, err);
        check($sformatf("wr 0x%02h pslverr", a), 32'(err), 32'd0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        logic err;
        apb_read(a, d, err);
        check(name, d, exp);
        check({name, " pslverr"}, 32'(err), 32'd0);
    endtask

    // Count consecutive negedge samples of PAN_PWM at the given level (bounded)
    task automatic pan_run(input logic lvl, output int n);
        n = 0;
        while (PAN_PWM == lvl && n < 300) begin
            n++;
            @(negedge PCLK);
        end
    endtask

    // Expected STATUS value e cycles after the FIRE write commits
    function automatic logic [31:0] status_at(input int e);
        if (e <= 4)  return 32'h5;
        if (e <= 12) return 32'h9;
        return 32'h2;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        err;
        int          n;
        int          hp;
        int          ht;
        int          fires;

        // Reset state of outputs
        @(posedge PCLK); #1;
        check("outputs in reset", 32'({PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR}), 32'd0);
        check("pready", 32'(PREADY), 32'd1);
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;

        vecs.push_back('{1'b0, A_CTRL,   32'h0,        32'd0,  1'b0});
        vecs.push_back('{1'b0, A_PAN,    32'h0,        32'd10, 1'b0});
        vecs.push_back('{1'b0, A_TILT,   32'h0,        32'd10, 1'b0});
        vecs.push_back('{1'b0, A_STATUS, 32'h0,        32'd0,  1'b0});
        vecs.push_back('{1'b0, A_FIRE,   32'h0,        32'd0,  1'b0});
        vecs.push_back('{1'b1, A_FIRE,   32'h1,        32'd0,  1'b0});
        vecs.push_back('{1'b0, A_STATUS, 32'h0,        32'd0,  1'b0});
        vecs.push_back('{1'b1, A_TILT,   32'd3,        32'd0,  1'b0});
        vecs.push_back('{1'b0, A_TILT,   32'h0,        32'd10, 1'b0});
        vecs.push_back('{1'b1, A_TILT,   32'd50,       32'd0,  1'b0});
        vecs.push_back('{1'b0, A_TILT,   32'h0,        32'd20, 1'b0});
        vecs.push_back('{1'b1, A_TILT,   32'd17,       32'd0,  1'b0});
        vecs.push_back('{1'b0, A_TILT,   32'h0,        32'd17, 1'b0});
        vecs.push_back('{1'b1, A_PAN,    32'hFFE0000C, 32'd0,  1'b0});
        vecs.push_back('{1'b0, A_PAN,    32'h0,        32'd12, 1'b0});
        vecs.push_back('{1'b0, 8'h14,    32'h0,        32'd0,  1'b1});
        vecs.push_back('{1'b1, 8'h14,    32'hF,        32'd0,  1'b1});
        vecs.push_back('{1'b1, 8'h05,    32'd15,       32'd0,  1'b1});
        vecs.push_back('{1'b0, A_PAN,    32'h0,        32'd12, 1'b0});
        vecs.push_back('{1'b0, A_TILT,   32'h0,        32'd17, 1'b0});
        vecs.push_back('{1'b0, A_CTRL,   32'h0,        32'd0,  1'b0});
        vecs.push_back('{1'b0, 8'h02,    32'h0,        32'd0,  1'b1});
        vecs.push_back('{1'b1, A_CTRL,   32'h3,        32'd0,  1'b0});
        vecs.push_back('{1'b0, A_CTRL,   32'h0,        32'd3,  1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, err);
                check($sformatf("vec%0d wr pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            end else begin
                apb_read(vecs[i].addr, d, err);
                check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
                check($sformatf("vec%0d rd pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            end
        end

        // Two full frames contain exactly two pulses per channel
        hp = 0; ht = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            hp += int'(PAN_PWM);
            ht += int'(TILT_PWM);
        end
        check("pan highs per 200", 32'(hp), 32'd24);
        check("tilt highs per 200", 32'(ht), 32'd34);

        // New width takes effect as a whole pulse at the next frame
        wr(A_PAN, 32'd15);
        @(negedge PCLK);
        pan_run(1'b1, n);
        pan_run(1'b0, n);
        check("pan wait rising", 32'(n < 300), 32'd1);
        pan_run(1'b1, n);
        check("pan pulse len 15", 32'(n), 32'd15);
        pan_run(1'b0, n);
        check("pan gap len 85", 32'(n), 32'd85);

        // Disabling stops both channels
        wr(A_CTRL, 32'h2);
        @(negedge PCLK);
        @(negedge PCLK);
        check("pwm low after EN clear", 32'({PAN_PWM, TILT_PWM}), 32'd0);
        hp = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge PCLK);
            hp += int'(PAN_PWM) + int'(TILT_PWM);
        end
        check("pwm idle while disabled", 32'(hp), 32'd0);

        // Shot with extra FIRE writes during FIRE and COOL
        wr(A_CTRL, 32'h3);
        wr(A_FIRE, 32'h1);
        fires = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge PCLK);
                    fires += int'(FIRE_OUT);
                end
            end
            begin
                wr(A_FIRE, 32'h1);
                wr(A_FIRE, 32'h1);
                wr(A_FIRE, 32'h1);
            end
        join
        check("fire_out high cycles", 32'(fires), 32'd5);
        rd(A_STATUS, 32'h2, "status done after shot");
        check("irq after shot", 32'(IRQ), 32'd1);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, 32'h2, "status W1C bit0 no effect");
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, 32'h0, "status done cleared");
        check("irq after clear", 32'(IRQ), 32'd0);

        // BUSY/state timeline sampled on odd then even cycles after FIRE commit
        for (int ph = 0; ph < 2; ph++) begin
            wr(A_FIRE, 32'h1);
            if (ph == 1) @(negedge PCLK);
            for (int k = 0; k < 7; k++) begin
                rd(A_STATUS, status_at(2 * k + 1 + ph),
                   $sformatf("status cyc %0d", 2 * k + 1 + ph));
            end
            wr(A_STATUS, 32'h2);
        end

        // Abort: clear EN two cycles into FIRE
        wr(A_FIRE, 32'h1);
        wr(A_CTRL, 32'h2);
        @(negedge PCLK);
        @(negedge PCLK);
        check("fire_out after abort", 32'(FIRE_OUT), 32'd0);
        rd(A_STATUS, 32'h0, "status after abort");
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            fires += int'(FIRE_OUT);
        end
        check("no fire after abort", 32'(fires), 32'd0);

        // Reset mid-pulse while firing
        wr(A_CTRL, 32'h3);
        @(negedge PCLK);
        pan_run(1'b0, n);
        check("pan wait before reset", 32'(n < 300), 32'd1);
        wr(A_FIRE, 32'h1);
        @(negedge PCLK);
        check("active before reset", 32'({PAN_PWM, TILT_PWM, FIRE_OUT}), 32'h7);
        PRESERN = 1'b0;
        @(posedge PCLK); #1;
        check("outputs at reset edge", 32'({PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR}), 32'd0);
        repeat (3) @(negedge PCLK);
        check("outputs held in reset", 32'({PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR}), 32'd0);
        PRESERN = 1'b1;
        rd(A_PAN, 32'd10, "pan after reset");
        rd(A_TILT, 32'd10, "tilt after reset");
        rd(A_CTRL, 32'd0, "ctrl after reset");
        rd(A_STATUS, 32'd0, "status after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
